// File: rtl/sphy_spi_receiver_if.sv
// rtl/sphy_spi_receiver_if.sv - SPHY SPI receiver bus: serial inputs and frame outputs
interface sphy_spi_receiver_if;
   logic        sclk;
   logic        mosi;
   logic        cs_n;
   logic [11:0] rx_data;
   logic [3:0]  rx_config;
   logic        rx_valid;
   logic        frame_err;
   logic        busy;
   logic [15:0] frame_count;

   modport master (
      output sclk, mosi, cs_n,
      input  rx_data, rx_config, rx_valid, frame_err, busy, frame_count
   );

   modport slave (
      input  sclk, mosi, cs_n,
      output rx_data, rx_config, rx_valid, frame_err, busy, frame_count
   );
endinterface

// File: rtl/sphy_spi_receiver.sv
// rtl/sphy_spi_receiver.sv - SPI frame receiver: synchronizes the bus, shifts 16-bit frames, validates config
module sphy_spi_receiver #(
   parameter logic [3:0] EXPECTED_CONFIG = 4'b0011,
   parameter int         SYNC_STAGES     = 2
) (
   input logic               clk,
   input logic               rst,
   sphy_spi_receiver_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] flush_q, flush_d;
   logic sclk_s, mosi_s, cs_s;
   logic sclk_dly_q, sclk_dly_d, cs_dly_q, cs_dly_d;
   logic sclk_fall_q, sclk_fall_d, cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;
   logic mosi_smp_q, mosi_smp_d;
   logic armed_q, armed_d, pending_q, pending_d;
   logic [1:0]  state_q, state_d;
   logic [15:0] shift_q, shift_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [11:0] rx_data_q, rx_data_d;
   logic [3:0]  rx_config_q, rx_config_d;
   logic        rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
   logic [15:0] frame_count_q, frame_count_d;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];

   always_comb begin
      sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      flush_d       = {flush_q[SYNC_STAGES-2:0], 1'b1};
      sclk_dly_d    = sclk_s;
      cs_dly_d      = cs_s;
      // Edges are registered together with the mosi sample so all three stay aligned.
      sclk_fall_d   = sclk_dly_q & ~sclk_s;
      cs_fall_d     = armed_q & cs_dly_q & ~cs_s;
      cs_rise_d     = ~cs_dly_q & cs_s;
      mosi_smp_d    = mosi_s;
      // A cs_n fall only counts once a real (post-reset) high level has been seen,
      // so a frame cut by reset is not picked up halfway.
      armed_d       = armed_q | (flush_q[SYNC_STAGES-1] & cs_s);
      pending_d     = pending_q;
      state_d       = state_q;
      shift_d       = shift_q;
      cnt_d         = cnt_q;
      rx_data_d     = rx_data_q;
      rx_config_d   = rx_config_q;
      rx_valid_d    = 1'b0;
      frame_err_d   = 1'b0;
      frame_count_d = frame_count_q;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall_q || pending_q) begin
               state_d   = ST_SHIFT;
               shift_d   = 16'h0000;
               cnt_d     = 5'd0;
               pending_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (sclk_fall_q) begin
               shift_d = {shift_q[14:0], mosi_smp_q};
               cnt_d   = (cnt_q == 5'd17) ? 5'd17 : cnt_q + 5'd1;
            end
            if (cs_rise_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (cs_fall_q) begin
               pending_d = 1'b1;
            end
            if ((cnt_q == 5'd16) && (shift_q[15:12] == EXPECTED_CONFIG)) begin
               rx_data_d     = shift_q[11:0];
               rx_config_d   = shift_q[15:12];
               rx_valid_d    = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q   <= '0;
         mosi_sync_q   <= '0;
         cs_sync_q     <= '1;
         flush_q       <= '0;
         sclk_dly_q    <= 1'b0;
         cs_dly_q      <= 1'b1;
         sclk_fall_q   <= 1'b0;
         cs_fall_q     <= 1'b0;
         cs_rise_q     <= 1'b0;
         mosi_smp_q    <= 1'b0;
         armed_q       <= 1'b0;
         pending_q     <= 1'b0;
         state_q       <= ST_IDLE;
         shift_q       <= 16'h0000;
         cnt_q         <= 5'd0;
         rx_data_q     <= 12'h000;
         rx_config_q   <= 4'h0;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         frame_count_q <= 16'h0000;
      end else begin
         sclk_sync_q   <= sclk_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         cs_sync_q     <= cs_sync_d;
         flush_q       <= flush_d;
         sclk_dly_q    <= sclk_dly_d;
         cs_dly_q      <= cs_dly_d;
         sclk_fall_q   <= sclk_fall_d;
         cs_fall_q     <= cs_fall_d;
         cs_rise_q     <= cs_rise_d;
         mosi_smp_q    <= mosi_smp_d;
         armed_q       <= armed_d;
         pending_q     <= pending_d;
         state_q       <= state_d;
         shift_q       <= shift_d;
         cnt_q         <= cnt_d;
         rx_data_q     <= rx_data_d;
         rx_config_q   <= rx_config_d;
         rx_valid_q    <= rx_valid_d;
         frame_err_q   <= frame_err_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign bus.rx_data     = rx_data_q;
   assign bus.rx_config   = rx_config_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.busy        = (state_q == ST_SHIFT);
   assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_sphy_spi_receiver.sv
// tb/tb_sphy_spi_receiver.sv - scoreboard bench for sphy_spi_receiver with randomized SPI frames
module tb_sphy_spi_receiver;
   localparam int         SYNC = 2;
   localparam logic [3:0] CFG  = 4'b0011;

   logic clk = 1'b0;
   logic rst;
   sphy_spi_receiver_if bus ();

   sphy_spi_receiver #(.EXPECTED_CONFIG(CFG), .SYNC_STAGES(SYNC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          ok;
      logic [11:0] data;
      logic [3:0]  cfg;
      logic [15:0] cnt;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [11:0] m_data;
   logic [3:0]  m_cfg;
   logic [15:0] m_cnt;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic model_reset();
      m_data = 12'h000;
      m_cfg  = 4'h0;
      m_cnt  = 16'h0000;
      sb.delete();
   endtask

   // Reference: a frame is accepted iff exactly 16 bits arrived and the top nibble matches.
   task automatic expect_frame(input logic [31:0] val, input int nbits);
      exp_t e;
      e.ok = (nbits == 16) && (val[15:12] == CFG);
      if (e.ok) begin
         m_data = val[11:0];
         m_cfg  = val[15:12];
         m_cnt  = m_cnt + 16'd1;
      end
      e.data = m_data;
      e.cfg  = m_cfg;
      e.cnt  = m_cnt;
      e.due  = cyc + SYNC + 3;
      sb.push_back(e);
   endtask

   task automatic send_bits(input logic [31:0] val, input int hi, input int lo, input int half);
      for (int i = hi; i >= lo; i--) begin
         bus.mosi = val[i];
         bus.sclk = 1'b1;
         tick(half);
         bus.sclk = 1'b0;
         tick(half);
      end
   endtask

   task automatic send_frame(input logic [31:0] val, input int nbits, input int half, input int idle);
      bus.cs_n = 1'b0;
      tick(half);
      if (nbits > 0) send_bits(val, nbits - 1, 0, half);
      if (nbits >= 2) chk("busy_in_frame", bus.busy, 1);
      bus.cs_n = 1'b1;
      expect_frame(val, nbits);
      tick(idle);
   endtask

   task automatic check_reset_outputs();
      chk("rst_rx_data", bus.rx_data, 0);
      chk("rst_rx_config", bus.rx_config, 0);
      chk("rst_rx_valid", bus.rx_valid, 0);
      chk("rst_frame_err", bus.frame_err, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_frame_count", bus.frame_count, 0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rx_valid && bus.frame_err) begin
            checks++;
            errors++;
            $display("FAIL both_pulses rx_valid %b frame_err %b required not both", bus.rx_valid, bus.frame_err);
         end
         if (bus.rx_valid || bus.frame_err) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse rx_valid %b frame_err %b required none", bus.rx_valid, bus.frame_err);
            end else begin
               mon_e = sb.pop_front();
               chk("pulse_kind_valid", bus.rx_valid, mon_e.ok);
               chk("pulse_latency", cyc, mon_e.due);
               chk("rx_data", bus.rx_data, mon_e.data);
               chk("rx_config", bus.rx_config, mon_e.cfg);
               chk("frame_count", bus.frame_count, mon_e.cnt);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int          nb;

      rst      = 1'b1;
      bus.sclk = 1'b0;
      bus.mosi = 1'b0;
      bus.cs_n = 1'b1;
      model_reset();
      tick(3);
      check_reset_outputs();
      rst = 1'b0;
      tick(5);

      send_frame(32'h3ABC, 16, 2, 8);
      send_frame(32'h5123, 16, 2, 8);
      send_frame(32'h0000_02AA, 10, 1, 8);
      send_frame(32'h0001_3456, 17, 3, 8);
      send_frame(32'h0000_0000, 0, 1, 8);
      send_frame(32'h3000, 16, 1, 2);
      send_frame(32'h3FFF, 16, 1, 8);
      send_frame(32'h3123, 16, 1, 1);
      send_frame(32'h3456, 16, 1, 8);

      // sclk activity with cs_n idle must be ignored
      for (int i = 0; i < 4; i++) begin
         bus.mosi = 1'($urandom);
         bus.sclk = 1'b1;
         tick(1);
         bus.sclk = 1'b0;
         tick(1);
      end
      tick(8);

      for (int k = 0; k < 40; k++) begin
         v  = $urandom;
         nb = ($urandom_range(0, 9) < 6) ? 16 : $urandom_range(0, 17);
         if ($urandom_range(0, 2) != 0) v[15:12] = CFG;
         send_frame(v, nb, $urandom_range(1, 3), $urandom_range(1, 6));
      end
      tick(20);
      chk("queue_drained_random", sb.size(), 0);

      // reset in the middle of a frame, remaining bits must be ignored
      bus.cs_n = 1'b0;
      tick(2);
      send_bits(32'h3555, 15, 8, 2);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check_reset_outputs();
      tick(1);
      send_bits(32'h3555, 7, 0, 2);
      bus.cs_n = 1'b1;
      tick(10);
      send_frame(32'h3AAA, 16, 2, 10);
      chk("after_reset_count", bus.frame_count, 1);
      chk("after_reset_data", bus.rx_data, 12'hAAA);

      // frame_count wrap
      @(negedge clk);
      force dut.frame_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count_q;
      m_cnt = 16'hFFFF;
      @(negedge clk);
      chk("count_preset", bus.frame_count, 16'hFFFF);
      tick(1);
      send_frame(32'h3777, 16, 1, 10);
      chk("count_wrapped", bus.frame_count, 16'h0000);
      chk("busy_idle", bus.busy, 0);

      for (int w = 0; w < 50 && sb.size() != 0; w++) tick(1);
      chk("queue_drained_final", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
